// File: rtl/vx_stream_demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer and its per-output slot.
package vx_stream_demux_pkg;

    // Width of the per-slot state word exposed for observation.
    localparam int SLOT_STATE_W = 2;

    // Select width: ceil(log2(n)), but never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_stream_demux_skid_buffer.sv
// One output slot: a main/skid register pair with registered ready, giving
// full throughput without a combinational ready path from consumer to producer.
module vx_stream_demux_skid_buffer
    import vx_stream_demux_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [DATAW-1:0]        data_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATAW-1:0]        data_out,
    input  logic                    ready_out,
    output logic [SLOT_STATE_W-1:0] state_dbg
);

    typedef enum logic [SLOT_STATE_W-1:0] {
        S_EMPTY = 2'b00,
        S_HALF  = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DATAW-1:0] main_q;
    logic [DATAW-1:0] skid_q;
    logic             ready_q;
    logic             push;
    logic             pop;
    logic             load_main;
    logic             refill_main;
    logic             load_skid;

    assign push = valid_in && ready_q;
    assign pop  = (state != S_EMPTY) && ready_out;

    always_comb begin
        state_n     = state;
        load_main   = 1'b0;
        refill_main = 1'b0;
        load_skid   = 1'b0;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    state_n   = S_HALF;
                    load_main = 1'b1;
                end
            end
            S_HALF: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    state_n   = S_FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_n = S_EMPTY;
                end
            end
            S_FULL: begin
                // Ready is low here, so only a drain of main can happen.
                if (pop) begin
                    state_n     = S_HALF;
                    refill_main = 1'b1;
                end
            end
            default: state_n = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n != S_FULL);
            if (load_main) begin
                main_q <= data_in;
            end else if (refill_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= data_in;
            end
        end
    end

    assign ready_in  = ready_q;
    assign valid_out = (state != S_EMPTY);
    assign data_out  = main_q;
    assign state_dbg = state;

endmodule

// File: rtl/vx_stream_demux.sv
// Valid/ready demultiplexer: steers each input beat to one of NUM_OUTPUTS
// streams by sel_in, optionally through a per-output skid buffer.
module vx_stream_demux
    import vx_stream_demux_pkg::*;
#(
    parameter int NUM_OUTPUTS = 4,
    parameter int DATAW       = 32,
    parameter int OUT_BUF     = 1,
    parameter int LN          = sel_width(NUM_OUTPUTS)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      valid_in,
    input  logic [DATAW-1:0]                          data_in,
    input  logic [LN-1:0]                             sel_in,
    output logic                                      ready_in,
    output logic [NUM_OUTPUTS-1:0]                    valid_out,
    output logic [NUM_OUTPUTS-1:0][DATAW-1:0]         data_out,
    input  logic [NUM_OUTPUTS-1:0]                    ready_out,
    output logic [NUM_OUTPUTS-1:0][SLOT_STATE_W-1:0]  slot_state
);

    // Handshake: a beat transfers on any edge where valid and ready are both
    // high; valid never waits on ready, and ready_in never looks at valid_in.

    localparam int NSEL = 1 << LN;

    logic [LN-1:0]   sel_idx;
    logic            sel_ok;
    logic [NSEL-1:0] slot_ready;

    generate
        if (NUM_OUTPUTS == 1) begin : g_single
            logic unused_sel;
            assign unused_sel = ^sel_in;
            assign sel_idx    = '0;
            assign sel_ok     = 1'b1;
        end else if (NUM_OUTPUTS == NSEL) begin : g_pow2
            assign sel_idx = sel_in;
            assign sel_ok  = 1'b1;
        end else begin : g_npow2
            assign sel_idx = sel_in;
            assign sel_ok  = (32'(sel_in) < 32'(NUM_OUTPUTS));
        end

        // Unpopulated select codes read as not-ready.
        if (NSEL > NUM_OUTPUTS) begin : g_pad
            assign slot_ready[NSEL-1:NUM_OUTPUTS] = '0;
        end

        if (OUT_BUF != 0) begin : g_buf
            for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_slot
                logic slot_valid_in;
                assign slot_valid_in = valid_in && sel_ok && (sel_idx == LN'(i));

                vx_stream_demux_skid_buffer #(
                    .DATAW (DATAW)
                ) u_slot (
                    .clk       (clk),
                    .reset     (reset),
                    .valid_in  (slot_valid_in),
                    .data_in   (data_in),
                    .ready_in  (slot_ready[i]),
                    .valid_out (valid_out[i]),
                    .data_out  (data_out[i]),
                    .ready_out (ready_out[i]),
                    .state_dbg (slot_state[i])
                );
            end
            // Slot ready is registered; reset masks it so nothing is taken while held.
            assign ready_in = !reset && sel_ok && slot_ready[sel_idx];
        end else begin : g_pass
            for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
                assign valid_out[i]  = valid_in && sel_ok && (sel_idx == LN'(i));
                assign data_out[i]   = data_in;
                assign slot_ready[i] = ready_out[i];
                assign slot_state[i] = '0;
            end
            assign ready_in = sel_ok && slot_ready[sel_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset && valid_in) begin
            assert (sel_ok)
            else $error("vx_stream_demux: select %0d out of range", sel_in);
        end
    end

endmodule

// File: tb/tb_vx_stream_demux.sv
// Self-checking bench for vx_stream_demux: buffered 4-output instance plus a
// 3-output pass-through instance for the non-power-of-2 select path.
module tb_vx_stream_demux;

    logic             clk;
    logic             reset;
    logic             valid_in;
    logic [31:0]      data_in;
    logic [1:0]       sel_in;
    logic             ready_in;
    logic [3:0]       valid_out;
    logic [3:0][31:0] data_out;
    logic [3:0]       ready_out;
    logic [3:0][1:0]  slot_state;

    logic             e_valid_in;
    logic [7:0]       e_data_in;
    logic [1:0]       e_sel_in;
    logic             e_ready_in;
    logic [2:0]       e_valid_out;
    logic [2:0][7:0]  e_data_out;
    logic [2:0]       e_ready_out;
    logic [2:0][1:0]  e_slot_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[4][$];

    vx_stream_demux #(.NUM_OUTPUTS(4), .DATAW(32), .OUT_BUF(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .sel_in     (sel_in),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .ready_out  (ready_out),
        .slot_state (slot_state)
    );

    vx_stream_demux #(.NUM_OUTPUTS(3), .DATAW(8), .OUT_BUF(0)) dut_pass (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (e_valid_in),
        .data_in    (e_data_in),
        .sel_in     (e_sel_in),
        .ready_in   (e_ready_in),
        .valid_out  (e_valid_out),
        .data_out   (e_data_out),
        .ready_out  (e_ready_out),
        .slot_state (e_slot_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard step: pops compared against expected, accepted beats queued.
    task automatic tick();
        #1;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (valid_out[i] && ready_out[i]) begin
                    check($sformatf("q%0d_nonempty", i), 64'(exp_q[i].size() != 0), 64'd1);
                    if (exp_q[i].size() != 0)
                        check($sformatf("pop%0d_data", i), 64'(data_out[i]), 64'(exp_q[i].pop_front()));
                end
            end
            if (valid_in && ready_in) exp_q[sel_in].push_back(data_in);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] data);
        valid_in = 1'b1;
        sel_in   = sel;
        data_in  = data;
        tick();
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_q%0d_empty", tag, i), 64'(exp_q[i].size()), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        valid_in    = 1'b1;
        data_in     = 32'hDEAD;
        sel_in      = 2'd0;
        ready_out   = 4'hF;
        e_valid_in  = 1'b0;
        e_data_in   = 8'h00;
        e_sel_in    = 2'd0;
        e_ready_out = 3'b000;

        // reset held two cycles with valid_in high
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_valid_out", 64'(valid_out), 64'd0);
            check("rst_ready_in", 64'(ready_in), 64'd0);
            check("rst_data_out0", 64'(data_out[0]), 64'd0);
        end
        reset    = 1'b0;
        valid_in = 1'b0;
        #1;
        check("post_rst_ready_in", 64'(ready_in), 64'd1);
        check("post_rst_valid_out", 64'(valid_out), 64'd0);

        // streaming round-robin, continuous ready
        for (int k = 0; k < 8; k++) begin
            valid_in = 1'b1;
            sel_in   = 2'(k % 4);
            data_in  = 32'hA0 + 32'(k);
            #1;
            check("stream_ready_in", 64'(ready_in), 64'd1);
            check("stream_valid_out", 64'(valid_out), (k == 0) ? 64'd0 : 64'(1 << ((k - 1) % 4)));
            tick();
        end
        valid_in = 1'b0;
        #1;
        check("stream_tail", 64'(valid_out), 64'b1000);
        tick();
        tick();
        check_drained("stream");

        // skid fill on output 2
        ready_out = 4'b1011;
        valid_in  = 1'b1;
        sel_in    = 2'd2;
        data_in   = 32'h11;
        #1 check("skid_rdy_11", 64'(ready_in), 64'd1);
        tick();
        data_in = 32'h22;
        #1 check("skid_rdy_22", 64'(ready_in), 64'd1);
        tick();
        data_in = 32'h33;
        #1;
        check("skid_rdy_33", 64'(ready_in), 64'd0);
        check("skid_state_full", 64'(slot_state[2]), 64'b10);
        check("skid_main", 64'(data_out[2]), 64'h11);
        tick();
        ready_out = 4'b1111;
        #1 check("skid_no_comb_ready", 64'(ready_in), 64'd0);
        tick();
        #1 check("skid_rdy_after_pop", 64'(ready_in), 64'd1);
        tick();
        valid_in = 1'b0;
        #1 check("skid_main_33", 64'(data_out[2]), 64'h33);
        tick();
        tick();
        check_drained("skid");

        // independence: output 1 stalled full, output 3 still flows
        ready_out = 4'b1101;
        drive(2'd1, 32'hB1);
        drive(2'd1, 32'hB2);
        sel_in  = 2'd1;
        data_in = 32'hB3;
        #1 check("indep_blocked", 64'(ready_in), 64'd0);
        sel_in  = 2'd3;
        data_in = 32'h55;
        #1 check("indep_ready3", 64'(ready_in), 64'd1);
        tick();
        valid_in = 1'b0;
        #1;
        check("indep_valid3", 64'(valid_out[3]), 64'd1);
        check("indep_data3", 64'(data_out[3]), 64'h55);
        check("indep_state1", 64'(slot_state[1]), 64'b10);
        tick();
        ready_out = 4'hF;
        tick();
        tick();
        tick();
        check_drained("indep");

        // mid-operation reset with outputs 0 and 1 full
        ready_out = 4'b0000;
        drive(2'd0, 32'hC0);
        drive(2'd0, 32'hC1);
        drive(2'd1, 32'hC2);
        drive(2'd1, 32'hC3);
        valid_in = 1'b0;
        #1;
        check("mid_state0", 64'(slot_state[0]), 64'b10);
        check("mid_state1", 64'(slot_state[1]), 64'b10);
        reset = 1'b1;
        #1 check("mid_rst_ready", 64'(ready_in), 64'd0);
        tick();
        reset = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        #1;
        check("mid_valid_out", 64'(valid_out), 64'd0);
        check("mid_states", 64'(slot_state), 64'd0);
        ready_out = 4'hF;
        drive(2'd0, 32'h77);
        valid_in = 1'b0;
        #1;
        check("mid_alone", 64'(valid_out), 64'b0001);
        check("mid_data", 64'(data_out[0]), 64'h77);
        tick();
        #1 check("mid_idle", 64'(valid_out), 64'd0);
        check_drained("mid");

        // randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            ready_out = 4'($urandom_range(0, 15));
            valid_in  = ($urandom_range(0, 3) != 0);
            sel_in    = 2'($urandom_range(0, 3));
            data_in   = $urandom;
            tick();
        end
        valid_in  = 1'b0;
        ready_out = 4'hF;
        for (int c = 0; c < 4; c++) tick();
        check("rand_idle", 64'(valid_out), 64'd0);
        check_drained("rand");

        // pass-through instance, three outputs
        e_valid_in  = 1'b1;
        e_sel_in    = 2'd1;
        e_data_in   = 8'h3C;
        e_ready_out = 3'b010;
        #1;
        check("pass_valid_out", 64'(e_valid_out), 64'b010);
        check("pass_data0", 64'(e_data_out[0]), 64'h3C);
        check("pass_data2", 64'(e_data_out[2]), 64'h3C);
        check("pass_ready", 64'(e_ready_in), 64'd1);
        e_ready_out = 3'b101;
        #1 check("pass_not_ready", 64'(e_ready_in), 64'd0);
        e_sel_in = 2'd2;
        #1;
        check("pass_valid_sel2", 64'(e_valid_out), 64'b100);
        check("pass_ready_sel2", 64'(e_ready_in), 64'd1);
        e_valid_in  = 1'b0;
        e_sel_in    = 2'd3;
        e_ready_out = 3'b111;
        #1;
        check("pass_illegal_ready", 64'(e_ready_in), 64'd0);
        check("pass_illegal_valid", 64'(e_valid_out), 64'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vx_stream_demux.md
# VX_stream_demux

Valid/ready stream demultiplexer: one input stream is steered to one of `NUM_OUTPUTS` output streams by a per-transfer select, with an optional per-output skid buffer that registers both data and backpressure. It is the distribution counterpart of the selection mux. It sits wherever a shared producer feeds per-lane or per-bank consumers, such as a dispatch to an issue slot or a response to a requester. Every accepted input beat appears on exactly one output, in order per output.

## Interface
- `NUM_OUTPUTS`, 4: number of output streams; must be ≥1.
- `DATAW`, 32: payload width in bits.
- `OUT_BUF`, 1: 0 = combinational pass-through; 1 = 2-entry skid buffer per output.
- `LN`, `$clog2(NUM_OUTPUTS)` floored at 1: select width.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high.
- `valid_in`, input, 1: input beat valid.
- `data_in`, input, `DATAW`: input payload.
- `sel_in`, input, `LN`: destination index, sampled with the beat; ignored when `NUM_OUTPUTS`=1.
- `ready_in`, output, 1: input beat accepted when `valid_in && ready_in`.
- `valid_out`, output, `[NUM_OUTPUTS]`: per-output valid.
- `data_out`, output, `[NUM_OUTPUTS][DATAW]`: per-output payload.
- `ready_out`, input, `[NUM_OUTPUTS]`: per-output consumer ready.

## Operation
- Push to output i: `valid_in && ready_in && sel_in==i`. Pop on output i: `valid_out[i] && ready_out[i]`.
- `ready_in` = `slot_ready[sel_in]`. It does not depend on `valid_in`.
- `sel_in >= NUM_OUTPUTS` is illegal (non-power-of-2 counts). In that case `ready_in`=0, nothing is accepted, and a runtime assertion fires.
- `OUT_BUF`=0:
  - `valid_out[i] = valid_in && sel_in==i`.
  - `data_out[i] = data_in` for all i.
  - `ready_in = ready_out[sel_in]`.
  - No state; `reset` is unused.
- `OUT_BUF`=1: each output has a main register and a skid register, with three states:
  - EMPTY, main invalid: push → HALF (main←data).
  - HALF, main valid, skid empty:
    - push&pop → HALF (main←data).
    - push&!pop → FULL (skid←data).
    - !push&pop → EMPTY.
    - neither → HALF.
  - FULL: `slot_ready`=0, so no push. Pop → HALF (main←skid). Otherwise hold.
  - `valid_out[i]` = state≠EMPTY. `data_out[i]` = main. `slot_ready[i]` = state≠FULL, a registered decode.
- Outputs are independent: a stall on one output never blocks beats addressed to another.
- Order is preserved per output. There is no ordering between outputs.

## Timing
- Reset (`OUT_BUF`=1):
  - All slots go to EMPTY.
  - `valid_out`=0 and `data_out`=0.
  - `ready_in`=0 while `reset` is high, then 1 in the first cycle after deassertion.
- Reset mid-operation discards all buffered beats. No pop is reported for them.
- Latency:
  - `OUT_BUF`=1: a beat pushed in cycle t is visible on `valid_out` at t+1.
  - `OUT_BUF`=0: same cycle.
- Throughput is 1 beat/cycle per output with continuous `ready_out`, for both settings.
- Backpressure:
  - `OUT_BUF`=1: `ready_in` for output i falls one cycle after the cycle in which i entered FULL. Because of the skid register, no beat is lost.
  - `ready_out` has no combinational path to `ready_in`.
- Simultaneous push and pop on the same slot in HALF: the new beat replaces main in the same edge, and the popped beat is the old main.
- Data registers load only on push or refill; otherwise they hold.

## Structure
- No shared-package typedefs are needed. The 2-bit slot state encoding stays local to the sub-module.
- Use `VX_platform.vh` macros for unused signals (`sel_in` when N=1, `reset` when `OUT_BUF`=0) and for the illegal-select assertion.
- Sub-module `VX_skid_buffer` (`DATAW`): holds one slot's state machine, main/skid registers, and `valid_in/ready_in/valid_out/ready_out`. Instantiate it in a generate loop of `NUM_OUTPUTS`, gated by `OUT_BUF`.

## Test plan
- Reset: hold `reset` 2 cycles with `valid_in`=1 → `valid_out`=0000, `ready_in`=0; after release, `ready_in`=1 in the first cycle.
- Streaming: N=4, `OUT_BUF`=1, `ready_out`=1111; push 0xA0..0xA7 with sel=0,1,2,3,0,1,2,3 → each output receives its two beats in order, one cycle after push, with no bubbles.
- Skid fill:
  - Setup: `ready_out[2]`=0; push 0x11, 0x22, 0x33, all to sel=2.
  - Expected: 0x11 and 0x22 are accepted; `ready_in`=0 for the 0x33 attempt; output 2 is FULL.
  - Then raise `ready_out[2]` → pops 0x11 then 0x22, after which 0x33 is accepted.
- Independence: output 1 stalled FULL; a push of 0x55 to sel=3 is accepted, and `valid_out[3]`=1 next cycle.
- Illegal select: N=3, push with sel=3 → `ready_in`=0, the assertion fires, and no `valid_out` changes.
- Mid-op reset: outputs 0 and 1 FULL, then assert `reset` for 1 cycle → all `valid_out`=0; the next push of 0x77 to sel=0 emerges alone.
